spi_master_24: RTL and testbench
================================

# spi_master_24

Fixed-format 24-bit SPI master (mode 0) that sits directly downstream of the front-panel controller and shares one physical SPI bus between the front-panel LCD and the switch expander. On a start pulse it latches a 24-bit MOSI word and drives an active-low chip select, SCLK and MOSI. It shifts in 24 MISO bits and presents them as a parallel word. Its `o_n_cs` feeds the front-panel controller's CS steering, which routes it to the LCD or the switch CS pin.

## Interface
- `CLK_DIV`, default 10: SCLK half-period in `i_clk` cycles; legal range ≥ 2.
- `CS_CYC`, default 4: cycle count for each of CS setup (CS low → first SCLK edge), CS hold (last SCLK fall → CS high) and the minimum CS-high gap between frames; legal range ≥ 1.
- `i_clk`  in  1  system clock; all logic runs on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_spi_start`  in  1  transfer request; sampled only in IDLE.
- `i_mosi_data`  in  24  word to transmit, MSB first; latched on the cycle start is accepted.
- `o_miso_data`  out  24  last received word; updated only at frame end.
- `o_spi_done`  out  1  one-cycle pulse at frame end.
- `o_busy`  out  1  high from accept until the return to IDLE.
- `o_n_cs`  out  1  SPI chip select, active low.
- `o_sclk`  out  1  SPI clock; idles low.
- `o_mosi`  out  1  SPI data out.
- `i_miso`  in  1  SPI data in.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: `o_busy`=0, `o_n_cs`=1, `o_sclk`=0. If `i_spi_start`=1 at a rising edge:
  - latch `i_mosi_data` into the TX shift register;
  - clear the RX shift register;
  - set `o_n_cs`=0, `o_mosi`=bit 23, `o_busy`=1;
  - go to SETUP.
- SETUP: hold for `CS_CYC` cycles, then go to SHIFT with the bit counter at 0.
- SHIFT: 24 SCLK periods, each `2*CLK_DIV` cycles (low phase first, then high phase).
  - On the edge where `o_sclk` goes 0→1, `i_miso` is shifted into the RX LSB (left shift).
  - On the edge where `o_sclk` goes 1→0, `o_mosi` advances to the next lower bit and the bit counter increments.
  - After the 24th falling edge, `o_sclk` stays 0 and the block goes to HOLD.
- HOLD: `o_n_cs` stays 0 for `CS_CYC` cycles. At exit, in the same edge:
  - `o_n_cs`=1;
  - `o_miso_data` ← RX register;
  - `o_spi_done`=1 for exactly one cycle;
  - go to GAP.
- GAP: `o_n_cs`=1 for `CS_CYC` cycles, then IDLE with `o_busy`=0.
- Boundary behaviour:
  - `i_spi_start` outside IDLE is ignored, not queued.
  - `i_spi_start` held high starts a new frame on the first IDLE cycle.
  - Changes to `i_mosi_data` after acceptance have no effect on the current frame.
  - `o_miso_data` holds its value between frames.
  - `o_mosi` holds bit 0 through HOLD and GAP, and returns to 0 on entry to IDLE.
- Reset, asserted at any time including mid-frame, immediately and asynchronously forces:
  - IDLE;
  - `o_n_cs`=1, `o_sclk`=0, `o_mosi`=0, `o_busy`=0, `o_spi_done`=0, `o_miso_data`=0;
  - all counters to 0.
  
  No partial word is ever published.

## Timing
- Reset values: `o_n_cs`=1; all other outputs 0.
- Let edge E0 be the rising edge that accepts start.
- `o_n_cs` falls at E0. The first SCLK rise is at E0+`CS_CYC`+`CLK_DIV`.
- Bit k (k=0..23): SCLK rises at E0+`CS_CYC`+(2k+1)·`CLK_DIV`, falls at E0+`CS_CYC`+(2k+2)·`CLK_DIV`.
- `o_n_cs` rises and `o_spi_done` pulses at E0+2·`CS_CYC`+48·`CLK_DIV`.
- `o_busy` falls at E0+3·`CS_CYC`+48·`CLK_DIV`. The earliest next accept is that same edge, if start is high.
- MOSI is stable for a full half-period before and after each SCLK rise.
- MISO is sampled directly, without a synchronizer; slave data must be valid at the SCLK rise.

## Test plan
- Reset: assert `i_rst` asynchronously between clock edges → outputs take reset values (`o_n_cs`=1, all others 0) before the next edge.
- Loopback (`i_miso`=`o_mosi`), `CLK_DIV`=4, `CS_CYC`=2, send 0xA5C3F0 → `o_miso_data`=0xA5C3F0; `o_spi_done` single pulse at E0+196; `o_busy` low at E0+198; exactly 24 SCLK rises.
- Slave model returns 0x123456 on SCLK falls while MOSI=0xFFFFFF → `o_miso_data`=0x123456; MOSI checked bit-by-bit MSB first, CS setup/hold = 2 cycles.
- Start pulse during SHIFT with a different word → ignored: the frame count stays 1 and the first word's MOSI is unchanged.
- Start held high for three frames → back-to-back frames with exactly `CS_CYC` cycles of CS high between them; three done pulses.
- Reset mid-SHIFT at bit 10, then a new frame of 0x00000F → CS returns high immediately; `o_miso_data` stays 0 until the new frame completes with the correct value.

Source files
------------

// File: rtl/spi_master_24_if.sv
// rtl/spi_master_24_if.sv - request/response and SPI pin bundle for spi_master_24
interface spi_master_24_if;
  logic        i_spi_start;
  logic [23:0] i_mosi_data;
  logic [23:0] o_miso_data;
  logic        o_spi_done;
  logic        o_busy;
  logic        o_n_cs;
  logic        o_sclk;
  logic        o_mosi;
  logic        i_miso;

  modport master (
    input  i_spi_start, i_mosi_data, i_miso,
    output o_miso_data, o_spi_done, o_busy, o_n_cs, o_sclk, o_mosi
  );

  modport slave (
    output i_spi_start, i_mosi_data, i_miso,
    input  o_miso_data, o_spi_done, o_busy, o_n_cs, o_sclk, o_mosi
  );
endinterface

// File: rtl/spi_master_24.sv
// rtl/spi_master_24.sv - fixed 24-bit mode-0 SPI master with CS setup/hold/gap timing
module spi_master_24 #(
  parameter int CLK_DIV = 10,
  parameter int CS_CYC  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  spi_master_24_if.master   bus
);

  localparam int CMAX = (CLK_DIV > CS_CYC) ? CLK_DIV : CS_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [4:0]    r_bit, w_bit;
  logic [23:0]   r_tx, w_tx;
  logic [23:0]   r_rx, w_rx;
  logic [23:0]   r_miso_data, w_miso_data;
  logic          r_done, w_done;
  logic          r_busy, w_busy;
  logic          r_n_cs, w_n_cs;
  logic          r_sclk, w_sclk;
  logic          r_mosi, w_mosi;
  logic          w_cs_end;
  logic          w_div_end;
  logic          w_accept;

  assign bus.o_miso_data = r_miso_data;
  assign bus.o_spi_done  = r_done;
  assign bus.o_busy      = r_busy;
  assign bus.o_n_cs      = r_n_cs;
  assign bus.o_sclk      = r_sclk;
  assign bus.o_mosi      = r_mosi;

  // State and datapath registers; reset drops everything mid-frame without publishing
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_miso_data <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_n_cs      <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_bit       <= w_bit;
      r_tx        <= w_tx;
      r_rx        <= w_rx;
      r_miso_data <= w_miso_data;
      r_done      <= w_done;
      r_busy      <= w_busy;
      r_n_cs      <= w_n_cs;
      r_sclk      <= w_sclk;
      r_mosi      <= w_mosi;
    end
  end

  // Next-state and output decode; the last GAP cycle doubles as the first IDLE
  // sample point so a held start gives exactly CS_CYC cycles of CS high between frames
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_bit       = r_bit;
    w_tx        = r_tx;
    w_rx        = r_rx;
    w_miso_data = r_miso_data;
    w_done      = 1'b0;
    w_busy      = r_busy;
    w_n_cs      = r_n_cs;
    w_sclk      = r_sclk;
    w_mosi      = r_mosi;
    w_cs_end    = (r_cnt == CW'(CS_CYC - 1));
    w_div_end   = (r_cnt == CW'(CLK_DIV - 1));
    w_accept    = bus.i_spi_start &&
                  ((r_state == S_IDLE) || ((r_state == S_GAP) && w_cs_end));

    case (r_state)
      S_SETUP: begin
        if (w_cs_end) begin
          w_state = S_SHIFT;
          w_cnt   = '0;
          w_bit   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_div_end) begin
          w_cnt = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
            w_rx   = {r_rx[22:0], bus.i_miso};
          end else begin
            w_sclk = 1'b0;
            w_bit  = r_bit + 1'b1;
            if (r_bit == 5'd23) begin
              w_state = S_HOLD;
            end else begin
              w_tx   = {r_tx[22:0], 1'b0};
              w_mosi = r_tx[22];
            end
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (w_cs_end) begin
          w_state     = S_GAP;
          w_cnt       = '0;
          w_n_cs      = 1'b1;
          w_miso_data = r_rx;
          w_done      = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (w_cs_end) begin
          w_state = S_IDLE;
          w_cnt   = '0;
          w_busy  = 1'b0;
          w_mosi  = 1'b0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt = '0;
      end
    endcase

    if (w_accept) begin
      w_state = S_SETUP;
      w_cnt   = '0;
      w_bit   = '0;
      w_tx    = bus.i_mosi_data;
      w_rx    = '0;
      w_n_cs  = 1'b0;
      w_mosi  = bus.i_mosi_data[23];
      w_busy  = 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_master_24.sv
// tb/tb_spi_master_24.sv - randomized self-checking bench for spi_master_24
module tb_spi_master_24;
  localparam int CD = 4;
  localparam int CS = 2;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] slave_word = '0;
  bit          loop_mode = 1'b1;
  logic        sbit = 1'b0;
  int          sidx = 0;
  logic        s_pcs = 1'b1;
  logic        s_psc = 1'b0;

  spi_master_24_if bus();

  spi_master_24 #(.CLK_DIV(CD), .CS_CYC(CS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.i_miso = loop_mode ? bus.o_mosi : sbit;

  // Slave: presents MSB at CS fall, next bit after each SCLK fall
  always @(negedge clk) begin
    if (s_pcs && !bus.o_n_cs) begin
      sidx = 23;
      sbit = slave_word[23];
    end else if (s_psc && !bus.o_sclk && sidx > 0) begin
      sidx = sidx - 1;
      sbit = slave_word[sidx];
    end
    s_pcs = bus.o_n_cs;
    s_psc = bus.o_sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ncs"},  {31'd0, bus.o_n_cs}, 32'd1);
    check({tag, "_sclk"}, {31'd0, bus.o_sclk}, 32'd0);
    check({tag, "_mosi"}, {31'd0, bus.o_mosi}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.o_spi_done}, 32'd0);
    check({tag, "_md"},   {8'd0, bus.o_miso_data}, 32'd0);
  endtask

  // One frame; expectations come from the timing formulas and the chosen slave behaviour
  task automatic run_frame(input logic [23:0] tx, input logic [23:0] sw, input bit lp, input int inj_t);
    int e0, t, rises, fr, lf, dn, dt, bt, csf;
    logic [23:0] mw, rxw, md0, exp_rx;
    logic pscl, pcs;
    bit to, early;
    @(negedge clk);
    bus.i_spi_start = 1'b1;
    bus.i_mosi_data = tx;
    slave_word = sw;
    loop_mode = lp;
    md0 = bus.o_miso_data;
    @(negedge clk);
    e0 = cyc;
    bus.i_spi_start = 1'b0;
    bus.i_mosi_data = 24'($urandom);
    check("cs_low_at_e0", {31'd0, bus.o_n_cs}, 32'd0);
    check("mosi_msb", {31'd0, bus.o_mosi}, {31'd0, tx[23]});
    rises = 0; fr = -1; lf = -1; dn = 0; dt = -1; bt = -1; csf = 0;
    mw = '0; rxw = '0; pscl = 1'b0; pcs = 1'b0; to = 1'b1; early = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      t = cyc - e0;
      if (t == inj_t) begin
        bus.i_spi_start = 1'b1;
        bus.i_mosi_data = ~tx;
      end else if (t == inj_t + 1) begin
        bus.i_spi_start = 1'b0;
      end
      if (!pscl && bus.o_sclk) begin
        rises++;
        mw = {mw[22:0], bus.o_mosi};
        if (rises == 1) fr = t;
      end
      if (pscl && !bus.o_sclk) lf = t;
      if (pcs && !bus.o_n_cs) csf++;
      if (dn == 0 && !bus.o_spi_done && bus.o_miso_data !== md0) early = 1'b1;
      if (bus.o_spi_done) begin
        dn++;
        dt = t;
        rxw = bus.o_miso_data;
      end
      if (!bus.o_busy) begin
        bt = t;
        to = 1'b0;
        break;
      end
      pscl = bus.o_sclk;
      pcs = bus.o_n_cs;
    end
    exp_rx = lp ? tx : sw;
    check("timeout", {31'd0, to}, 32'd0);
    check("rx_word", {8'd0, rxw}, {8'd0, exp_rx});
    check("mosi_word", {8'd0, mw}, {8'd0, tx});
    check("sclk_rises", rises, 24);
    check("first_rise_t", fr, CS + CD);
    check("last_fall_t", lf, CS + 48 * CD);
    check("done_t", dt, 2 * CS + 48 * CD);
    check("done_pulses", dn, 1);
    check("busy_fall_t", bt, 3 * CS + 48 * CD);
    check("extra_cs_fall", csf, 0);
    check("md_early_change", {31'd0, early}, 32'd0);
    check("idle_mosi", {31'd0, bus.o_mosi}, 32'd0);
    repeat (5) @(negedge clk);
    check("md_hold", {8'd0, bus.o_miso_data}, {8'd0, exp_rx});
    check("idle_ncs", {31'd0, bus.o_n_cs}, 32'd1);
  endtask

  task automatic reset_mid_frame();
    logic pscl;
    int falls;
    bit to;
    @(negedge clk);
    bus.i_spi_start = 1'b1;
    bus.i_mosi_data = 24'($urandom);
    loop_mode = 1'b1;
    @(negedge clk);
    bus.i_spi_start = 1'b0;
    pscl = 1'b0; falls = 0; to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pscl && !bus.o_sclk) falls++;
      pscl = bus.o_sclk;
      if (falls == 10) begin
        to = 1'b0;
        break;
      end
    end
    check("rst_mid_timeout", {31'd0, to}, 32'd0);
    check("rst_mid_busy_before", {31'd0, bus.o_busy}, 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic held_start();
    int e0, t, csf, dn, trise, gaps;
    logic pcs;
    logic [23:0] w;
    bit to;
    w = 24'($urandom);
    @(negedge clk);
    loop_mode = 1'b1;
    bus.i_spi_start = 1'b1;
    bus.i_mosi_data = w;
    e0 = cyc;
    pcs = 1'b1; csf = 0; dn = 0; trise = -1; gaps = 0; to = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      t = cyc - e0;
      if (pcs && !bus.o_n_cs) begin
        csf++;
        if (trise >= 0) begin
          check("b2b_cs_gap", t - trise, CS);
          gaps++;
        end
        if (csf == 3) bus.i_spi_start = 1'b0;
      end
      if (!pcs && bus.o_n_cs) trise = t;
      if (bus.o_spi_done) begin
        dn++;
        check("b2b_rx", {8'd0, bus.o_miso_data}, {8'd0, w});
      end
      if (csf == 3 && !bus.o_busy) begin
        to = 1'b0;
        break;
      end
      pcs = bus.o_n_cs;
    end
    check("b2b_timeout", {31'd0, to}, 32'd0);
    check("b2b_done_pulses", dn, 3);
    check("b2b_gaps", gaps, 2);
    check("b2b_cs_falls", csf, 3);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_spi_start = 1'b0;
    bus.i_mosi_data = '0;
    #2 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    reset_mid_frame();
    run_frame(24'h00000F, 24'h0, 1'b1, -1);

    run_frame(24'hA5C3F0, 24'h0, 1'b1, -1);
    run_frame(24'hFFFFFF, 24'h123456, 1'b0, -1);
    run_frame(24'h3C3C3C, 24'h0, 1'b1, 60);

    for (int n = 0; n < 4; n++) begin
      run_frame(24'($urandom), 24'($urandom), n[0], ($urandom_range(0, 1) == 1) ? int'($urandom_range(10, 180)) : -1);
    end

    held_start();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
